// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI master and its tick generator.
package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } spi_state_e;

  // Number of SCK edges in one transfer: a leading and a trailing edge per bit.
  function automatic int edge_count(input int data_w);
    return 2 * data_w;
  endfunction

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period tick generator: tick_o pulses once every CLK_DIV enabled cycles.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick_o
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick_o = enable && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// Full-duplex SPI master, all four CPOL/CPHA modes, one DATA_W-bit word per request.
// Optional build macro SPI_LSB_FIRST_EN adds lsb_first_i for LSB-first framing.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [1:0]        mode_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              SCK,
  output logic              SS,
  output logic              MOSI,
  input  logic              MISO
`ifdef SPI_LSB_FIRST_EN
  ,
  input  logic              lsb_first_i
`endif
);

  localparam int EDGES = edge_count(DATA_W);
  localparam int EW    = $clog2(EDGES + 1);
  localparam logic [EW-1:0] LAST_EDGE  = EW'(EDGES);
  localparam logic [EW-1:0] LAST_TRAIL = EW'(EDGES - 1);

  spi_state_e        state, state_next;
  spi_mode_t         mode_in, mode_q;
  logic              lsb_in, lsb_q;
  logic              accept, tick, clk_en;
  logic              sck_edge, leading, drive_bit, sample_bit;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_q;
  logic              sck_q, ss_q, mosi_q;

  assign mode_in = spi_mode_t'(mode_i);
`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first_i;
`else
  assign lsb_in = 1'b0;
`endif

  assign accept = start_i && (state == IDLE);
  assign clk_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .enable(clk_en),
    .clear (accept),
    .tick_o(tick)
  );

  // The tick closing SETUP makes the first edge; the tick after the last edge only ends the half-period.
  assign sck_edge   = tick && ((state == SETUP) || ((state == SHIFT) && (edge_cnt != LAST_EDGE)));
  assign leading    = ~edge_cnt[0];
  assign drive_bit  = sck_edge && (mode_q.cpha ? leading : (!leading && (edge_cnt != LAST_TRAIL)));
  assign sample_bit = sck_edge && (mode_q.cpha ? !leading : leading);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = SETUP;
      SETUP:   if (tick) state_next = SHIFT;
      SHIFT:   if (tick && (edge_cnt == LAST_EDGE)) state_next = HOLD;
      HOLD:    if (tick) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    busy_o  = (state != IDLE);
    done_o  = (state == DONE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      edge_cnt <= '0;
    end else if (accept) begin
      edge_cnt <= '0;
    end else if (sck_edge) begin
      edge_cnt <= edge_cnt + EW'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mode_q <= '0;
      lsb_q  <= 1'b0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      rx_q   <= '0;
      sck_q  <= 1'b0;
      ss_q   <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      ss_q <= !((state_next == SETUP) || (state_next == SHIFT) || (state_next == HOLD));
      if (accept) begin
        mode_q <= mode_in;
        lsb_q  <= lsb_in;
        sck_q  <= mode_in.cpol;
        rx_sh  <= '0;
        // CPHA=0 presents the first bit while SS falls; CPHA=1 waits for the leading edge.
        if (!mode_in.cpha) begin
          mosi_q <= lsb_in ? tx_data_i[0] : tx_data_i[DATA_W-1];
          tx_sh  <= lsb_in ? (tx_data_i >> 1) : (tx_data_i << 1);
        end else begin
          mosi_q <= 1'b0;
          tx_sh  <= tx_data_i;
        end
      end else if (sck_edge) begin
        sck_q <= ~sck_q;
        if (drive_bit) begin
          mosi_q <= lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
          tx_sh  <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
        end
        if (sample_bit) begin
          rx_sh <= lsb_q ? {MISO, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], MISO};
        end
      end
      if ((state == HOLD) && tick) begin
        rx_q   <= rx_sh;
        mosi_q <= 1'b0;
      end
    end
  end

  assign SCK       = sck_q;
  assign SS        = ss_q;
  assign MOSI      = mosi_q;
  assign rx_data_o = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master with a behavioural SPI slave on the pins.
module tb_spi_master;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int LAT = (2 * W + 2) * D + 1;
  localparam int SS_LOW = (2 * W + 2) * D;

  typedef struct packed {
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic [7:0] word;
  } cfg_t;

  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] rx;
    logic       cpol;
  } exp_t;

  logic         PCLK      = 1'b0;
  logic         PRESETn   = 1'b0;
  logic         start_i   = 1'b0;
  logic [W-1:0] tx_data_i = '0;
  logic [1:0]   mode_i    = 2'b00;
  logic         MISO      = 1'b0;
  logic         ready_o, busy_o, done_o, SCK, SS, MOSI;
  logic [W-1:0] rx_data_o;
`ifdef SPI_LSB_FIRST_EN
  logic         lsb_first_i = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cfg_t cfg_q[$];
  exp_t exp_q[$];

  spi_master #(
    .DATA_W (W),
    .CLK_DIV(D)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .start_i  (start_i),
    .tx_data_i(tx_data_i),
    .mode_i   (mode_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .rx_data_o(rx_data_o),
    .SCK      (SCK),
    .SS       (SS),
    .MOSI     (MOSI),
    .MISO     (MISO)
`ifdef SPI_LSB_FIRST_EN
    ,
    .lsb_first_i(lsb_first_i)
`endif
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept tracking on the active edge (pre-edge values).
  int cyc = 0, acc_cyc = 0, acc_n = 0;
  always @(posedge PCLK) begin
    cyc++;
    if (PRESETn && start_i && ready_o) begin
      acc_cyc = cyc;
      acc_n++;
    end
  end

  // Slave model: samples/drives on the falling PCLK edge after each SCK change.
  cfg_t       cur = '0;
  logic [7:0] s_sh = '0, s_rx = '0;
  int         s_bits = 0;
  logic       s_prev_ss = 1'b1, s_prev_sck = 1'b0, s_lead;
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      s_prev_ss = 1'b1;
      MISO = 1'b0;
    end else begin
      if (s_prev_ss && !SS) begin
        if (cfg_q.size() > 0) cur = cfg_q.pop_front();
        s_sh = cur.word;
        s_rx = '0;
        s_bits = 0;
        s_prev_sck = SCK;
        if (cur.cpha) MISO = 1'b0;
        else begin
          MISO = cur.lsb ? s_sh[0] : s_sh[7];
          s_sh = cur.lsb ? (s_sh >> 1) : (s_sh << 1);
        end
      end else if (!SS && (SCK !== s_prev_sck)) begin
        s_lead = (SCK !== cur.cpol);
        if (s_lead != cur.cpha) begin
          s_rx = cur.lsb ? {MOSI, s_rx[7:1]} : {s_rx[6:0], MOSI};
          s_bits++;
        end else begin
          MISO = cur.lsb ? s_sh[0] : s_sh[7];
          s_sh = cur.lsb ? (s_sh >> 1) : (s_sh << 1);
        end
        s_prev_sck = SCK;
      end
      s_prev_ss = SS;
    end
  end

  // Output monitor: pops the scoreboard on every done_o.
  int         ss_low = 0, ss_high = 0, done_cnt = 0, mosi_ones = 0, xfer_n = 0;
  logic       m_prev_ss = 1'b1, had_xfer = 1'b0, rx_hold_chk = 1'b0, idle_cpol = 1'b0;
  logic [7:0] last_rx = '0;
  exp_t       e;
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      m_prev_ss = 1'b1;
      ss_low = 0;
      ss_high = 0;
      rx_hold_chk = 1'b0;
    end else begin
      if (!SS) begin
        if (m_prev_ss && had_xfer) check_eq("ss_gap_ge2", 32'(ss_high >= 2), 1);
        ss_low = m_prev_ss ? 1 : ss_low + 1;
      end else begin
        ss_high = m_prev_ss ? ss_high + 1 : 1;
      end
      if (MOSI) mosi_ones++;
      if (rx_hold_chk) begin
        check_eq("rx_hold", rx_data_o, last_rx);
        rx_hold_chk = 1'b0;
      end
      if (done_o) begin
        done_cnt++;
        check_eq("done_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          xfer_n++;
          $display("xfer %0d: tx=%02h rx=%02h lat=%0d ss_low=%0d", xfer_n, e.tx, rx_data_o,
                   cyc - acc_cyc + 1, ss_low);
          check_eq("rx_data", rx_data_o, e.rx);
          check_eq("slave_got_mosi", s_rx, e.tx);
          check_eq("slave_bits", s_bits, W);
          check_eq("latency", cyc - acc_cyc + 1, LAT);
          check_eq("ss_low_cycles", ss_low, SS_LOW);
          check_eq("sck_idle_at_done", SCK, e.cpol);
          check_eq("busy_at_done", busy_o, 1);
          idle_cpol = e.cpol;
          last_rx = rx_data_o;
          rx_hold_chk = 1'b1;
        end
        had_xfer = 1'b1;
      end
      m_prev_ss = SS;
    end
  end

  task automatic push_xfer(input logic [1:0] mode, input logic [7:0] tx, input logic [7:0] sword,
                           input logic lsb);
    cfg_q.push_back('{mode[1], mode[0], lsb, sword});
    exp_q.push_back('{tx, sword, mode[1]});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && exp_q.size() > 0; i++) @(negedge PCLK);
    check_eq("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge PCLK);
  endtask

  task automatic do_xfer(input logic [1:0] mode, input logic [7:0] tx, input logic [7:0] sword,
                         input logic lsb);
    for (int i = 0; i < 500 && !ready_o; i++) @(negedge PCLK);
    check_eq("ready_before_start", ready_o, 1);
    check_eq("sck_idle_before", SCK, idle_cpol);
    push_xfer(mode, tx, sword, lsb);
    start_i   = 1'b1;
    tx_data_i = tx;
    mode_i    = mode;
`ifdef SPI_LSB_FIRST_EN
    lsb_first_i = lsb;
`endif
    @(negedge PCLK);
    start_i   = 1'b0;
    tx_data_i = 8'($urandom);
    mode_i    = 2'($urandom);
`ifdef SPI_LSB_FIRST_EN
    lsb_first_i = ~lsb;
`endif
    wait_drain();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0, a0;
  initial begin
    repeat (3) @(negedge PCLK);
    #1;
    check_eq("rst_ss", SS, 1);
    check_eq("rst_sck", SCK, 0);
    check_eq("rst_mosi", MOSI, 0);
    check_eq("rst_rx", rx_data_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_busy", busy_o, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_eq("ready_after_rst", ready_o, 1);

    // Mode 0 and mode 3 single transfers.
    do_xfer(2'b00, 8'hA5, 8'h3C, 1'b0);
    do_xfer(2'b11, 8'h81, 8'hFF, 1'b0);

    // Mode 1 then mode 2 back-to-back with start_i held high.
    d0 = done_cnt;
    a0 = acc_n;
    push_xfer(2'b01, 8'h3C, 8'h99, 1'b0);
    push_xfer(2'b10, 8'hC3, 8'h5A, 1'b0);
    start_i = 1'b1;
    mode_i = 2'b01;
    tx_data_i = 8'h3C;
    for (int i = 0; i < 200 && acc_n == a0; i++) @(negedge PCLK);
    check_eq("b2b_accept1", acc_n - a0, 1);
    mode_i = 2'b10;
    tx_data_i = 8'hC3;
    for (int i = 0; i < 200 && acc_n == a0 + 1; i++) @(negedge PCLK);
    check_eq("b2b_accept2", acc_n - a0, 2);
    start_i = 1'b0;
    wait_drain();
    check_eq("b2b_done_pulses", done_cnt - d0, 2);

    // start_i pulsed in the middle of a running all-zero transfer.
    d0 = done_cnt;
    mosi_ones = 0;
    push_xfer(2'b00, 8'h00, 8'h96, 1'b0);
    start_i = 1'b1;
    tx_data_i = 8'h00;
    mode_i = 2'b00;
    @(negedge PCLK);
    start_i = 1'b0;
    for (int i = 0; i < 200 && s_bits != 3; i++) @(negedge PCLK);
    check_eq("mid_bit3_reached", s_bits, 3);
    start_i = 1'b1;
    tx_data_i = 8'hFF;
    @(negedge PCLK);
    start_i = 1'b0;
    wait_drain();
    check_eq("mid_single_done", done_cnt - d0, 1);
    check_eq("mid_mosi_ones", mosi_ones, 0);

    // Reset after three SCK rises of a mode-0 transfer.
    push_xfer(2'b00, 8'h77, 8'hE1, 1'b0);
    start_i = 1'b1;
    tx_data_i = 8'h77;
    mode_i = 2'b00;
    @(negedge PCLK);
    start_i = 1'b0;
    for (int i = 0; i < 200 && s_bits != 3; i++) @(negedge PCLK);
    check_eq("rst_mid_rises", s_bits, 3);
    d0 = done_cnt;
    PRESETn = 1'b0;
    #1;
    check_eq("rst_mid_ss", SS, 1);
    check_eq("rst_mid_sck", SCK, 0);
    check_eq("rst_mid_mosi", MOSI, 0);
    check_eq("rst_mid_busy", busy_o, 0);
    exp_q.delete();
    cfg_q.delete();
    idle_cpol = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_eq("rst_mid_no_done", done_cnt - d0, 0);
    check_eq("rst_mid_rx_cleared", rx_data_o, 0);
    do_xfer(2'b00, 8'h5A, 8'hC6, 1'b0);

`ifdef SPI_LSB_FIRST_EN
    // LSB-first framing: slave returns 1 then zeros.
    do_xfer(2'b00, 8'h01, 8'h01, 1'b1);
    do_xfer(2'b01, 8'h34, 8'hB2, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
